// File: rtl/reg_seq_engine_pkg.sv
// Shared encodings and parameter limits for the register sequence engine.
package reg_seq_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ADC  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 32;
    localparam int NREGS_MIN = 3;
    localparam int NREGS_MAX = 16;

endpackage

// File: rtl/reg_seq_engine_if.sv
// Control, readback and status bundle of the register sequence engine.
interface reg_seq_engine_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       mode;
    logic             halt_on_carry;
    logic [WIDTH-1:0] init_val;
    logic [3:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rout;
    logic [1:0]       state;
    logic [3:0]       step;
    logic             busy;
    logic             done;
    logic             carry_flag;
    logic             overflow_flag;

    modport master (
        output start, mode, halt_on_carry, init_val, rd_addr,
        input  rd_data, rout, state, step, busy, done, carry_flag, overflow_flag
    );

    modport slave (
        input  start, mode, halt_on_carry, init_val, rd_addr,
        output rd_data, rout, state, step, busy, done, carry_flag, overflow_flag
    );
endinterface

// File: rtl/reg_seq_engine_alu.sv
// Single-step arithmetic: add / subtract / add-with-carry with carry and signed overflow.
module seq_step_alu
    import reg_seq_engine_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    logic [WIDTH:0]          ext;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] r_s;

    always_comb begin
        ext = {1'b0, a} + {1'b0, b};
        case (mode)
            MODE_SUB: ext = {1'b0, a} - {1'b0, b};
            MODE_ADC: ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
            default:  ext = {1'b0, a} + {1'b0, b};
        endcase
    end

    // Bit WIDTH of the extended result is the carry for add and the borrow (a < b) for sub.
    assign result    = ext[WIDTH-1:0];
    assign carry_out = ext[WIDTH];

    assign a_s = $signed(a);
    assign b_s = $signed(b);
    assign r_s = $signed(result);

    always_comb begin
        overflow = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (r_s[WIDTH-1] != a_s[WIDTH-1]);
        if (mode == MODE_SUB) begin
            overflow = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (r_s[WIDTH-1] != a_s[WIDTH-1]);
        end
    end
endmodule

// File: rtl/reg_seq_engine.sv
// Register sequence engine: seeds r0/r1, then fills r[i] = f(r[i-1], r[i-2]) one per cycle.
module reg_seq_engine
    import reg_seq_engine_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input logic             clk,
    input logic             reset,
    reg_seq_engine_if.slave bus
);
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] regs [NREGS_MAX];
    logic [3:0]       idx_q;
    logic [1:0]       mode_q;
    logic             hoc_q;
    logic [WIDTH-1:0] init_q;
    logic [WIDTH-1:0] rout_q;
    logic [3:0]       step_q;
    logic             carry_q;
    logic             ovf_q;
    logic             finish_q;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             accept;
    logic             run_wr;
    logic             last_wr;

    seq_step_alu #(.WIDTH(WIDTH)) u_alu (
        .mode      (mode_q),
        .a         (regs[idx_q - 4'd1]),
        .b         (regs[idx_q - 4'd2]),
        .carry_in  (carry_q),
        .result    (alu_res),
        .carry_out (alu_carry),
        .overflow  (alu_ovf)
    );

    assign accept  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // The last write only arms finish_q; the following RUN cycle moves to DONE, which
    // places done exactly NREGS edges after the accepting edge.
    assign run_wr  = (state_q == ST_RUN) && !finish_q;
    assign last_wr = (idx_q == 4'(NREGS - 1)) || (hoc_q && alu_carry);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (finish_q) state_d = ST_DONE;
            ST_DONE: if (bus.start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            mode_q   <= 2'd0;
            hoc_q    <= 1'b0;
            init_q   <= '0;
            rout_q   <= '0;
            step_q   <= 4'd0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            finish_q <= 1'b0;
            for (int k = 0; k < NREGS_MAX; k++) regs[k] <= '0;
        end else begin
            state_q <= state_d;
            // Run inputs are captured once at acceptance so later input changes cannot leak in.
            if (accept) begin
                mode_q <= bus.mode;
                hoc_q  <= bus.halt_on_carry;
                init_q <= bus.init_val;
            end
            if (state_q == ST_LOAD) begin
                for (int k = 0; k < NREGS_MAX; k++) regs[k] <= (k < 2) ? init_q : '0;
                rout_q   <= init_q;
                step_q   <= 4'd1;
                idx_q    <= 4'd2;
                carry_q  <= 1'b0;
                ovf_q    <= 1'b0;
                finish_q <= 1'b0;
            end else if (run_wr) begin
                regs[idx_q] <= alu_res;
                rout_q      <= alu_res;
                step_q      <= idx_q;
                carry_q     <= alu_carry;
                ovf_q       <= ovf_q | alu_ovf;
                idx_q       <= idx_q + 4'd1;
                finish_q    <= last_wr;
            end
        end
    end

    assign bus.rd_data       = (int'(bus.rd_addr) < NREGS) ? regs[bus.rd_addr] : '0;
    assign bus.rout          = rout_q;
    assign bus.state         = state_q;
    assign bus.step          = step_q;
    assign bus.busy          = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.carry_flag    = carry_q;
    assign bus.overflow_flag = ovf_q;
endmodule

// File: tb/tb_reg_seq_engine.sv
// Directed bench for reg_seq_engine with a reference model feeding a write scoreboard.
module tb_reg_seq_engine;
    import reg_seq_engine_pkg::*;

    typedef struct {
        logic [3:0]  step;
        logic [15:0] val;
        logic        carry;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   lat;

    wr_t         sb_q[$];
    logic [15:0] m_regs [16];
    logic        m_carry;
    logic        m_ovf;
    logic [3:0]  m_step;

    always #5 clk = ~clk;

    reg_seq_engine_if #(.WIDTH(16)) bus ();
    reg_seq_engine_if #(.WIDTH(16)) bus8 ();

    reg_seq_engine #(.WIDTH(16), .NREGS(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    reg_seq_engine #(.WIDTH(16), .NREGS(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of a complete run; every write it predicts goes to the scoreboard.
    task automatic model_run(input logic [1:0] md, input logic hoc, input logic [15:0] init);
        int unsigned ua, ub, full;
        int          sa, sb, sr;
        logic        cy;
        for (int k = 0; k < 16; k++) m_regs[k] = 16'h0;
        m_regs[0] = init;
        m_regs[1] = init;
        m_carry   = 1'b0;
        m_ovf     = 1'b0;
        m_step    = 4'd1;
        for (int i = 2; i < 16; i++) begin
            ua = m_regs[i-1];
            ub = m_regs[i-2];
            sa = $signed(m_regs[i-1]);
            sb = $signed(m_regs[i-2]);
            if (md == 2'd1) begin
                full = ua - ub;
                sr   = sa - sb;
                cy   = (ua < ub);
            end else if (md == 2'd2) begin
                full = ua + ub + m_carry;
                sr   = sa + sb + m_carry;
                cy   = (full > 32'h0000_FFFF);
            end else begin
                full = ua + ub;
                sr   = sa + sb;
                cy   = (full > 32'h0000_FFFF);
            end
            m_regs[i] = full[15:0];
            m_carry   = cy;
            m_step    = 4'(i);
            if (sr > 32767 || sr < -32768) m_ovf = 1'b1;
            sb_q.push_back('{step: 4'(i), val: full[15:0], carry: cy});
            if (hoc && cy) break;
        end
    endtask

    task automatic start_run(input logic [1:0] md, input logic hoc, input logic [15:0] init);
        @(negedge clk);
        bus.mode          = md;
        bus.halt_on_carry = hoc;
        bus.init_val      = init;
        bus.start         = 1'b1;
        model_run(md, hoc, init);
    endtask

    // Watches the run, pops one scoreboard entry per register write, returns the done latency.
    task automatic wait_done(input int budget, input bit hold, input bit scramble, output int latency);
        int         n;
        logic [3:0] prev_step;
        wr_t        e;
        n         = 0;
        prev_step = 4'd1;
        latency   = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (n == 1 && !hold) begin
                bus.start  = 1'b0;
                bus8.start = 1'b0;
            end
            if (n == 1 && scramble) begin
                bus.mode          = ~bus.mode;
                bus.halt_on_carry = ~bus.halt_on_carry;
                bus.init_val      = 16'hFFFF;
            end
            if (bus.state == ST_RUN && bus.step != prev_step) begin
                prev_step = bus.step;
                if (sb_q.size() == 0) begin
                    check("unexpected_write_step", bus.step, 4'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("wr_step_%0d", e.step), bus.step, e.step);
                    check($sformatf("wr_rout_%0d", e.step), bus.rout, e.val);
                    check($sformatf("wr_carry_%0d", e.step), bus.carry_flag, e.carry);
                end
            end
            if (bus.done) begin
                latency = n - 1;
                break;
            end
        end
        bus.start = 1'b0;
        check("done_seen", bus.done, 1'b1);
        check("sb_drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
        bus.rd_addr = a;
        #1;
        d = bus.rd_data;
    endtask

    task automatic check_all_regs(input string tag);
        logic [15:0] d;
        for (int k = 0; k < 16; k++) begin
            read_reg(4'(k), d);
            check($sformatf("%s_r%0d", tag, k), d, m_regs[k]);
        end
        check({tag, "_step"}, bus.step, m_step);
        check({tag, "_carry"}, bus.carry_flag, m_carry);
        check({tag, "_ovf"}, bus.overflow_flag, m_ovf);
    endtask

    initial begin
        logic [15:0] d;
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.mode           = 2'd0;
        bus.halt_on_carry  = 1'b0;
        bus.init_val       = 16'h0;
        bus.rd_addr        = 4'd0;
        bus8.start         = 1'b0;
        bus8.mode          = 2'd0;
        bus8.halt_on_carry = 1'b0;
        bus8.init_val      = 16'h0;
        bus8.rd_addr       = 4'd15;

        repeat (2) @(negedge clk);
        check("rst_state", bus.state, ST_IDLE);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_rout", bus.rout, 16'h0);
        check("rst_step", bus.step, 4'h0);
        check("rst_flags", {bus.carry_flag, bus.overflow_flag}, 2'b00);
        reset = 1'b0;

        // Fibonacci add run, with the 8-register instance started alongside.
        bus8.init_val = 16'h0001;
        bus8.start    = 1'b1;
        start_run(2'd0, 1'b0, 16'h0001);
        wait_done(40, 1'b0, 1'b0, lat);
        check("add_latency", lat, 16);
        check_all_regs("add");
        read_reg(4'd15, d);
        check("add_r15", d, 16'h03DB);
        read_reg(4'd2, d);
        check("add_r2", d, 16'h0002);
        check("add_rout", bus.rout, 16'h03DB);
        check("n8_done", bus8.done, 1'b1);
        bus8.rd_addr = 4'd7;
        #1;
        check("n8_r7", bus8.rd_data, 16'h0015);
        bus8.rd_addr = 4'd15;
        #1;
        check("n8_r15_zero", bus8.rd_data, 16'h0000);

        // Halt on the first carry.
        start_run(2'd0, 1'b1, 16'h4000);
        wait_done(40, 1'b0, 1'b0, lat);
        check("halt_latency", lat, 5);
        check_all_regs("halt");
        read_reg(4'd2, d);
        check("halt_r2", d, 16'h8000);
        read_reg(4'd3, d);
        check("halt_r3", d, 16'hC000);
        read_reg(4'd4, d);
        check("halt_r4", d, 16'h4000);
        read_reg(4'd5, d);
        check("halt_r5", d, 16'h0000);
        check("halt_step", bus.step, 4'd4);
        check("halt_flags", {bus.carry_flag, bus.overflow_flag}, 2'b11);

        // Subtract run; run inputs are flipped right after acceptance and must be ignored.
        start_run(2'd1, 1'b0, 16'h0005);
        wait_done(40, 1'b0, 1'b1, lat);
        check("sub_latency", lat, 16);
        check_all_regs("sub");
        read_reg(4'd3, d);
        check("sub_r3", d, 16'hFFFB);

        // Asynchronous reset in the middle of a run.
        start_run(2'd0, 1'b0, 16'h0001);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 30 && bus.step != 4'd7; k++) @(negedge clk);
        check("mid_reach_step7", bus.step, 4'd7);
        reset = 1'b1;
        #1;
        check("mid_rst_state", bus.state, ST_IDLE);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_rout_step", {bus.rout, bus.step}, 20'h0);
        check("mid_rst_flags", {bus.carry_flag, bus.overflow_flag}, 2'b00);
        for (int k = 0; k < 16; k++) begin
            read_reg(4'(k), d);
            check($sformatf("mid_rst_r%0d", k), d, 16'h0);
        end
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        // Reserved mode encoding behaves as add.
        start_run(2'd3, 1'b0, 16'h0003);
        wait_done(40, 1'b0, 1'b0, lat);
        check("post_rst_latency", lat, 16);
        check_all_regs("post_rst");

        // start held high for the whole run must not restart it.
        start_run(2'd0, 1'b0, 16'h0001);
        wait_done(40, 1'b1, 1'b0, lat);
        check("hold_latency", lat, 16);
        read_reg(4'd15, d);
        check("hold_r15", d, 16'h03DB);
        repeat (3) @(negedge clk);
        check("done_hold_state", bus.state, ST_DONE);
        read_reg(4'd15, d);
        check("done_hold_r15", d, 16'h03DB);

        start_run(2'd0, 1'b0, 16'h0002);
        wait_done(40, 1'b0, 1'b0, lat);
        check("restart_latency", lat, 16);
        check_all_regs("restart");
        read_reg(4'd15, d);
        check("restart_r15", d, 16'h07B6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_seq_engine.md
REG_SEQ_ENGINE -- requirements
Module: reg_seq_engine

Interface
REQ-001 Parameter WIDTH, default 16: data width of every register, in bits; legal range 4..32.
REQ-002 Parameter NREGS, default 16: number of registers; legal range 3..16.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to begin a sequence run.
REQ-006 Port mode, input, 2 bits: operation select; 00 add, 01 sub, 10 add-with-carry, 11 treated as add.
REQ-007 Port halt_on_carry, input, 1 bit: stop the run early when a step produces a carry or borrow.
REQ-008 Port init_val, input, WIDTH bits: seed value written into r0 and r1.
REQ-009 Port rd_addr, input, 4 bits: readback register index.
REQ-010 Port rd_data, output, WIDTH bits: combinational read of r[rd_addr]; reads 0 when rd_addr >= NREGS.
REQ-011 Port rout, output, WIDTH bits: value written in the most recent step.
REQ-012 Port state, output, 2 bits: current state; IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-013 Port step, output, 4 bits: index of the register written in the most recent step.
REQ-014 Port busy, output, 1 bit: high in LOAD and RUN.
REQ-015 Port done, output, 1 bit: high in DONE.
REQ-016 Port carry_flag, output, 1 bit: carry or borrow out of the most recent step.
REQ-017 Port overflow_flag, output, 1 bit: sticky signed-overflow flag for the current run.

Function
REQ-018 IDLE: start=1 at an edge shall latch mode and halt_on_carry and go to LOAD; start=0 stays in IDLE.
REQ-019 LOAD (one cycle): write r0=r1=init_val and clear r2..r[NREGS-1], carry_flag, overflow_flag; set rout=init_val, step=1; go to RUN with index i=2.
REQ-020 RUN: one write per cycle, r[i] <= f(r[i-1], r[i-2]):
- add: r[i-1]+r[i-2]
- sub: r[i-1]-r[i-2]
- add-with-carry: r[i-1]+r[i-2]+carry_flag
Result truncated to WIDTH.
REQ-021 Each RUN write shall also update rout=result, step=i, and carry_flag (carry out; for sub, borrow = r[i-1] < r[i-2] unsigned).
REQ-022 overflow_flag shall be set on two's-complement overflow of any RUN step and held until the next LOAD or reset.
REQ-023 After the write to i=NREGS-1, the block shall go to DONE.
REQ-024 If halt_on_carry is latched and a step's carry_flag=1, that step's result shall still be written, then the block goes to DONE; later registers are untouched.
REQ-025 Latency: done shall assert NREGS edges after the edge that sampled start in IDLE (16 for the defaults).
REQ-026 start shall be ignored in LOAD and RUN.
REQ-027 DONE: outputs and registers hold; start=1 restarts at LOAD with freshly latched inputs.
REQ-028 mode, halt_on_carry and init_val changes during a run shall not affect that run.

Reset
REQ-029 reset=1 shall immediately force state=IDLE and clear all registers, rout, step, busy, done, carry_flag and overflow_flag, including mid-run.
REQ-030 After reset deasserts, the first start shall be honoured on the next edge.

Structure
REQ-031 A shared package shall hold the state encodings, the mode encodings, and the parameter legal-range constants.
REQ-032 The step arithmetic (result, carry, overflow) shall be one combinational sub-module, seq_step_alu, parametrised by WIDTH.
REQ-033 The register array and the FSM shall reside in reg_seq_engine.

Verification
REQ-034 The bench shall cover the following directed scenarios (defaults, WIDTH=16, NREGS=16):
- Add, init 1, start -> r15=0x03DB, r2=0x0002, done 16 cycles after the start edge, carry=0, overflow=0.
- Add, halt_on_carry=1, init 0x4000 -> r2=0x8000 (overflow=1), r3=0xC000, r4=0x4000 with carry=1 -> DONE, step=4, r5=0.
- Sub, init 5 -> r2=0x0000 with carry=0, r3=0xFFFB with carry=1; run completes to r15 with halt_on_carry=0.
- reset pulse during RUN at step=7 -> state=IDLE, all registers and flags 0; next start runs normally.
- start held high through RUN -> no restart; after DONE, start with init 2 -> r15=0x07B6.
- rd_addr=15 with NREGS=8 -> rd_data=0.
